// File: rtl/borrow_select_subtractor_pipe.sv
// Pipelined borrow-select subtractor: D = A - B - Bin over a non-uniform block partition.
// One register stage per block. Stage 0 ripples block 0 with Bin. Every later stage precomputes
// its block difference for borrow-in 0 and 1, then selects with the previous stage's borrow.
// Each stage has a valid bit, and the pipeline uses valid/ready handshakes with bubble collapse.
module borrow_select_subtractor_pipe #(
  parameter int unsigned WIDTH                 = 32,
  parameter int unsigned BLOCK_AMOUNT          = 4,
  parameter int unsigned BLOCKS [BLOCK_AMOUNT] = '{4, 10, 18, 32}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             Z,
  output logic             Ovf
);

  // Operand bits below block 1 are consumed in stage 0, so they are never carried forward.
  localparam int unsigned OpLo = BLOCKS[0];

  logic [BLOCK_AMOUNT-1:0] r_valid;
  logic [BLOCK_AMOUNT-1:0] r_borrow;
  logic [BLOCK_AMOUNT-1:0] r_amsb;
  logic [BLOCK_AMOUNT-1:0] r_bmsb;
  logic [WIDTH-1:0]        r_d [BLOCK_AMOUNT];
  logic [WIDTH-1:OpLo]     r_a [BLOCK_AMOUNT];
  logic [WIDTH-1:OpLo]     r_b [BLOCK_AMOUNT];
  logic [BLOCK_AMOUNT-1:0] w_ready;

  for (genvar k = 0; k < BLOCK_AMOUNT; k++) begin : g_stage
    localparam int unsigned Lo = (k == 0) ? 0 : BLOCKS[(k == 0) ? 0 : k - 1];
    localparam int unsigned Hi = BLOCKS[k];
    localparam int unsigned Bw = Hi - Lo;

    logic                w_up_valid;
    logic [WIDTH-1:OpLo] w_a_up;
    logic [WIDTH-1:OpLo] w_b_up;
    logic                w_amsb_up;
    logic                w_bmsb_up;
    logic [WIDTH-1:0]    w_d_up;
    logic [Bw-1:0]       w_diff;
    logic                w_bout;
    logic [WIDTH-1:0]    w_d_next;

    // Stage k may advance unless it and every stage after it are full and the output is blocked.
    assign w_ready[k] = out_ready | ~(&r_valid[BLOCK_AMOUNT-1:k]);

    if (k == 0) begin : g_first
      logic [Bw:0] w_sum;

      assign w_up_valid = in_valid;
      assign w_a_up     = A[WIDTH-1:OpLo];
      assign w_b_up     = B[WIDTH-1:OpLo];
      assign w_amsb_up  = A[WIDTH-1];
      assign w_bmsb_up  = B[WIDTH-1];
      assign w_d_up     = '0;
      // X + ~Y + ~bin; the carry-out is the inverse of the borrow-out.
      assign w_sum      = {1'b0, A[Hi-1:Lo]} + {1'b0, ~B[Hi-1:Lo]} + {{Bw{1'b0}}, ~Bin};
      assign w_diff     = w_sum[Bw-1:0];
      assign w_bout     = ~w_sum[Bw];
    end else begin : g_rest
      logic [Bw:0] w_sum_b0;
      logic [Bw:0] w_sum_b1;

      assign w_up_valid = r_valid[k-1];
      assign w_a_up     = r_a[k-1];
      assign w_b_up     = r_b[k-1];
      assign w_amsb_up  = r_amsb[k-1];
      assign w_bmsb_up  = r_bmsb[k-1];
      assign w_d_up     = r_d[k-1];
      // Both borrow-in cases are precomputed; the upstream borrow only drives the mux.
      assign w_sum_b0   = {1'b0, r_a[k-1][Hi-1:Lo]} + {1'b0, ~r_b[k-1][Hi-1:Lo]}
                          + {{Bw{1'b0}}, 1'b1};
      assign w_sum_b1   = {1'b0, r_a[k-1][Hi-1:Lo]} + {1'b0, ~r_b[k-1][Hi-1:Lo]};
      assign w_diff     = r_borrow[k-1] ? w_sum_b1[Bw-1:0] : w_sum_b0[Bw-1:0];
      assign w_bout     = r_borrow[k-1] ? ~w_sum_b1[Bw] : ~w_sum_b0[Bw];
    end

    // Merge this block's difference into the lower result bits coming from upstream.
    always_comb begin
      w_d_next         = w_d_up;
      w_d_next[Hi-1:Lo] = w_diff;
    end

    // Stage register: holds when not advancing, and loads contents only on a real transfer.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_valid[k]  <= 1'b0;
        r_borrow[k] <= 1'b0;
        r_amsb[k]   <= 1'b0;
        r_bmsb[k]   <= 1'b0;
        r_d[k]      <= '0;
        r_a[k]      <= '0;
        r_b[k]      <= '0;
      end else if (w_ready[k]) begin
        r_valid[k] <= w_up_valid;
        if (w_up_valid) begin
          r_borrow[k] <= w_bout;
          r_amsb[k]   <= w_amsb_up;
          r_bmsb[k]   <= w_bmsb_up;
          r_d[k]      <= w_d_next;
          r_a[k]      <= w_a_up;
          r_b[k]      <= w_b_up;
        end
      end
    end
  end

  // Nothing is accepted while reset is held, even though all stages read as empty.
  assign in_ready  = w_ready[0] & ~rst;
  assign out_valid = r_valid[BLOCK_AMOUNT-1];
  assign D         = r_d[BLOCK_AMOUNT-1];
  assign Bout      = r_borrow[BLOCK_AMOUNT-1];
  assign Z         = ~|r_d[BLOCK_AMOUNT-1];
  assign Ovf       = (r_amsb[BLOCK_AMOUNT-1] ^ r_bmsb[BLOCK_AMOUNT-1])
                     & (r_d[BLOCK_AMOUNT-1][WIDTH-1] ^ r_amsb[BLOCK_AMOUNT-1]);

endmodule

// File: tb/tb_borrow_select_subtractor_pipe.sv
// Scoreboard bench for borrow_select_subtractor_pipe: the driver pushes reference results on
// acceptance, and the monitor pops and compares on every output transfer.
module tb_borrow_select_subtractor_pipe;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bout;
    logic         z;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] D;
  logic         Bout;
  logic         Z;
  logic         Ovf;

  res_t exp_q[$];
  int   pop_cyc_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_pop = 0;
  int   cyc = 0;
  int   last_acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  borrow_select_subtractor_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .Bout      (Bout),
    .Z         (Z),
    .Ovf       (Ovf)
  );

  // Reference: plain integer arithmetic on the operands.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic bin);
    res_t   r;
    longint diff;
    diff   = longint'(a) - longint'(b) - longint'(bin);
    r.d    = diff[W-1:0];
    r.bout = (diff < 0);
    r.z    = (r.d == '0);
    r.ovf  = (a[W-1] != b[W-1]) && (r.d[W-1] != a[W-1]);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic rand_bit();
    return ($urandom_range(0, 1) == 1);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the item has been accepted.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int waited = 0;
    in_valid = 1'b1;
    A        = a;
    B        = b;
    Bin      = bin;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(a, b, bin));
        last_acc_cyc = cyc;
        break;
      end
      waited++;
      if (waited > 50) begin
        check("send_timeout", 64'(waited), 64'(0));
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_latency(input string name, input int acc);
    int seen = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = cyc;
        break;
      end
    end
    check(name, 64'(seen - acc), 64'(4));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_outstanding", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output transfer must match the oldest outstanding reference result.
  always @(negedge clk) begin : monitor
    res_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("out_d", 64'(D), 64'(e.d));
        check("out_bout", 64'(Bout), 64'(e.bout));
        check("out_z", 64'(Z), 64'(e.z));
        check("out_ovf", 64'(Ovf), 64'(e.ovf));
        n_pop++;
        pop_cyc_q.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   first_acc;
    int   pop0;
    int   vcount;
    int   p_first;
    int   p_last;
    res_t snap;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;
    Bin       = 1'b0;

    // Reset state.
    #12;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_d", 64'(D), 64'(0));
    check("rst_bout", 64'(Bout), 64'(0));
    check("rst_z", 64'(Z), 64'(1));
    check("rst_ovf", 64'(Ovf), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'(1));

    // Basic subtract and its latency.
    send(32'h0000_0005, 32'h3, 1'b0);
    check_latency("basic_latency", last_acc_cyc);
    drain();

    // Borrow, zero, cross-block borrow and overflow cases, back to back.
    send(32'h0, 32'h1, 1'b0);
    send(32'h5, 32'h5, 1'b1);
    send(32'h7, 32'h7, 1'b0);
    send(32'h0004_0000, 32'h1, 1'b0);
    send(32'h8000_0000, 32'h1, 1'b0);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    drain();

    // Streaming: 8 random back-to-back transfers give 8 consecutive results.
    pop_cyc_q.delete();
    send($urandom, $urandom, rand_bit());
    first_acc = last_acc_cyc;
    for (int i = 1; i < 8; i++) send($urandom, $urandom, rand_bit());
    drain();
    check("stream_count", 64'(pop_cyc_q.size()), 64'(8));
    if (pop_cyc_q.size() == 8) begin
      p_first = pop_cyc_q[0];
      p_last  = pop_cyc_q[7];
      check("stream_first_latency", 64'(p_first - first_acc), 64'(4));
      check("stream_consecutive", 64'(p_last - p_first), 64'(7));
    end

    // Backpressure: stall the output for 3 cycles after the first result.
    pop0 = n_pop;
    fork
      begin : bp_send
        for (int i = 0; i < 6; i++) send($urandom, $urandom, rand_bit());
      end
      begin : bp_stall
        int seen = 0;
        for (int n = 0; n < 40; n++) begin
          @(negedge clk);
          if (out_valid) begin
            seen = 1;
            break;
          end
        end
        check("bp_first_valid", 64'(seen), 64'(1));
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        snap = '{d: D, bout: Bout, z: Z, ovf: Ovf};
        check("bp_in_ready_full", 64'(in_ready), 64'(0));
        check("bp_out_valid", 64'(out_valid), 64'(1));
        for (int n = 0; n < 2; n++) begin
          @(negedge clk);
          check("bp_stable_d", 64'(D), 64'(snap.d));
          check("bp_stable_bout", 64'(Bout), 64'(snap.bout));
          check("bp_stable_z", 64'(Z), 64'(snap.z));
          check("bp_stable_ovf", 64'(Ovf), 64'(snap.ovf));
          check("bp_stall_valid", 64'(out_valid), 64'(1));
          check("bp_stall_in_ready", 64'(in_ready), 64'(0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_result_count", 64'(n_pop - pop0), 64'(6));

    // Reset mid-flight: the oldest item has just reached the output register.
    for (int i = 0; i < 3; i++) send($urandom, $urandom, rand_bit());
    @(posedge clk);
    #2;
    check("midrst_pre_valid", 64'(out_valid), 64'(1));
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_release_in_ready", 64'(in_ready), 64'(1));
    vcount = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check("midrst_no_stale", 64'(vcount), 64'(0));
    @(posedge clk);
    #1;
    send($urandom, $urandom, rand_bit());
    check_latency("midrst_new_latency", last_acc_cyc);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/borrow_select_subtractor_pipe.md
# borrow_select_subtractor_pipe

Pipelined, parameterizable borrow-select subtractor computing D = A − B − Bin over the same non-uniform block partition as the team's carry-select adder. It is the subtraction counterpart of that adder for the datapath. Each block boundary is a register stage, and each stage precomputes its block difference for both possible borrow-ins, then selects with the registered borrow from the previous stage. Operands enter and results leave through valid/ready handshakes with full backpressure and one result per cycle throughput.

## Interface
- WIDTH, 32, operand/result width.
- BLOCK_AMOUNT, 4, number of blocks, which equals the number of pipeline stages.
- BLOCKS[0:3], '{4, 10, 18, 32}, exclusive upper bit bound of each block.
  - Block i covers bits [BLOCKS[i]-1 : BLOCKS[i-1]], and block 0 covers [BLOCKS[0]-1 : 0].
  - Values must be strictly increasing, and BLOCKS[BLOCK_AMOUNT-1] must equal WIDTH.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  stage 0 can accept.
- A  in  WIDTH  minuend.
- B  in  WIDTH  subtrahend.
- Bin  in  1  borrow-in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- D  out  WIDTH  difference, A − B − Bin mod 2^WIDTH.
- Bout  out  1  borrow-out; 1 when unsigned A < B + Bin.
- Z  out  1  D == 0.
- Ovf  out  1  two's-complement signed overflow.

## Operation
- **Arithmetic:** each block computes X + ~Y + ~bin_in. The block's borrow-out is the inverse of that carry-out.
- **Stage 0:** ripple over block 0 using Bin. Registers the block-0 difference, the borrow, the untouched A/B slices of the higher blocks, the A/B MSBs and valid.
- **Stage i ≥ 1:**
  - Two ripple subtractors over the block-i slices, with fixed borrow-in 0 and 1.
  - A mux driven by the registered borrow of stage i−1 selects both the block difference and the block borrow-out.
  - Lower result slices, remaining operand slices, MSBs and valid pass forward.
- **Outputs:** the last stage register drives D and Bout directly.
  - Z = NOR of D, combinational from the register.
  - Ovf = (A_msb ≠ B_msb) & (D_msb ≠ A_msb), computed from the registered MSBs.
- **Handshake:**
  - Stage k advance condition: ready_k = !valid_k | ready_{k+1}, with ready_BLOCK_AMOUNT = out_ready.
  - in_ready = ready_0. A transfer occurs on any edge where valid & ready are both 1.
  - A stage that is not advancing holds all its contents unchanged.
  - Bubbles collapse: an empty stage accepts even when downstream is stalled.
- **Ordering:** results leave strictly in acceptance order. No result is dropped or duplicated.
- **Output stability:** while out_valid=1 and out_ready=0, D, Bout, Z and Ovf stay stable.

## Timing
- **Reset values, asynchronous:**
  - All valid bits 0, all data registers 0.
  - Outputs: out_valid=0, D=0, Bout=0, Z=1, Ovf=0.
  - in_ready=0 while rst=1, and 1 in the first cycle after release.
- **Latency:**
  - A transfer accepted in cycle t yields out_valid=1 in cycle t+BLOCK_AMOUNT (cycle t+4 by default), provided no stall occurs.
  - Each stalled cycle adds one cycle.
- **Throughput:** one result per cycle when out_ready is held at 1.
- **Simultaneous events:**
  - A pipeline full of 4 items with out_ready=1 still has in_ready=1: the output drains and the input fills in the same edge.
  - With out_ready=0 and all stages valid, in_ready=0.
- **Combinational paths:** in_ready depends on out_ready and the stage valids. There is no combinational path from A, B or Bin to any output.
- **Reset mid-operation:** all in-flight items are discarded immediately and out_valid drops asynchronously. No stale result appears after release.
- **Critical path:** the widest block ripple plus one 2:1 mux (14 bits by default).

## Test plan
- **Basic subtract:** A=0x0000_0005, B=0x3, Bin=0 accepted in cycle t → cycle t+4: out_valid=1, D=0x0000_0002, Bout=0, Z=0, Ovf=0.
- **Borrow and zero cases:**
  - A=0, B=1 → D=0xFFFF_FFFF, Bout=1, Ovf=0.
  - A=5, B=5, Bin=1 → D=0xFFFF_FFFF, Bout=1.
  - A=7, B=7, Bin=0 → D=0, Z=1, Bout=0.
- **Cross-block borrow and overflow:**
  - A=0x0004_0000, B=1 → D=0x0003_FFFF, Bout=0. This exercises borrow selection through blocks 0→1→2→3.
  - A=0x8000_0000, B=1 → D=0x7FFF_FFFF, Ovf=1, Bout=0.
- **Streaming:** 8 back-to-back random transfers with out_ready=1 → 8 consecutive out_valid cycles starting at t+4, all matching a reference model, in order.
- **Backpressure:**
  - Send 6 back-to-back transfers, and hold out_ready=0 for the 3 cycles after the first out_valid.
  - Required: in_ready=0 once all 4 stages are valid, outputs stay stable while stalled, and all 6 results arrive in order with none lost.
- **Reset mid-flight:** 3 items in flight, then rst pulses mid-cycle → out_valid=0 immediately. After release, in_ready=1, no output appears until a new transfer is accepted, and that transfer's result arrives 4 cycles later and is correct.
